// File: rtl/rob_multiport_pkg.sv
// Shared ROB sizing, index/pointer types and the per-entry record.
// Pointers carry one extra wrap bit above the entry index.
package rob_multiport_pkg;

  localparam int NUM_ROB_ENTS = 64;
  localparam int DISP_WIDTH   = 2;
  localparam int RETIRE_WIDTH = 2;
  localparam int NUM_FUS      = 4;
  localparam int NUM_AREGS    = 32;
  localparam int NUM_PREGS    = 128;

  localparam int ROB_IDX_W = $clog2(NUM_ROB_ENTS);
  localparam int PTR_W     = ROB_IDX_W + 1;
  localparam int COUNT_W   = $clog2(NUM_ROB_ENTS + 1);
  localparam int AREG_W    = $clog2(NUM_AREGS);
  localparam int PREG_W    = $clog2(NUM_PREGS);
  localparam int DCNT_W    = $clog2(DISP_WIDTH + 1);
  localparam int RCNT_W    = $clog2(RETIRE_WIDTH + 1);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [PTR_W-1:0]     rob_ptr_t;
  typedef logic [AREG_W-1:0]    areg_t;
  typedef logic [PREG_W-1:0]    preg_t;

  typedef struct packed {
    areg_t areg;
    preg_t preg;
    preg_t old_preg;
    logic  is_branch;
    logic  done;
    logic  mispred;
  } ROB_Entry;

  function automatic logic [DCNT_W-1:0] disp_popcount(input logic [DISP_WIDTH-1:0] v);
    logic [DCNT_W-1:0] n;
    n = DCNT_W'(0);
    for (int i = 0; i < DISP_WIDTH; i++) begin
      n = n + DCNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/rob_retire_sel.sv
// In-order retire prefix selection over the head window.
// A mispredicted lane retires but stops the prefix; it then raises flush.
module rob_retire_sel
  import rob_multiport_pkg::*;
(
  input  logic [RETIRE_WIDTH-1:0] win_valid,
  input  logic [RETIRE_WIDTH-1:0] win_done,
  input  logic [RETIRE_WIDTH-1:0] win_mispred,
  output logic [RETIRE_WIDTH-1:0] ret_valid,
  output logic [RCNT_W-1:0]       ret_cnt,
  output logic                    flush
);

  logic chain_s;

  // Prefix walk: each lane retires only if every older lane retired cleanly
  always_comb begin
    ret_valid = '0;
    ret_cnt   = RCNT_W'(0);
    flush     = 1'b0;
    chain_s   = 1'b1;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      ret_valid[k] = chain_s & win_valid[k] & win_done[k];
      ret_cnt      = ret_cnt + RCNT_W'(ret_valid[k]);
      flush        = ret_valid[k] ? win_mispred[k] : flush;
      chain_s      = ret_valid[k] & ~win_mispred[k];
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Multi-port reorder buffer: in-order allocate and retire, out-of-order completion,
// whole-window flush when a mispredicted branch retires.
module rob_multiport
  import rob_multiport_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DISP_WIDTH-1:0]                  disp_valid,
  input  logic [DISP_WIDTH-1:0][AREG_W-1:0]      disp_areg,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]      disp_preg,
  input  logic [DISP_WIDTH-1:0][PREG_W-1:0]      disp_old_preg,
  input  logic [DISP_WIDTH-1:0]                  disp_is_branch,
  output logic                                   disp_ready,
  output logic [DISP_WIDTH-1:0][ROB_IDX_W-1:0]   disp_rob_idx,
  input  logic [NUM_FUS-1:0]                     cmp_valid,
  input  logic [NUM_FUS-1:0][ROB_IDX_W-1:0]      cmp_rob_idx,
  input  logic [NUM_FUS-1:0]                     cmp_mispred,
  output logic [RETIRE_WIDTH-1:0]                ret_valid,
  output logic [RETIRE_WIDTH-1:0][AREG_W-1:0]    ret_areg,
  output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    ret_preg,
  output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]    ret_old_preg,
  output logic                                   flush,
  output logic [COUNT_W-1:0]                     rob_count,
  output logic                                   rob_empty
);

  logic [NUM_ROB_ENTS-1:0] valid_r;
  ROB_Entry                ents_r [NUM_ROB_ENTS];
  rob_ptr_t                head_r;
  rob_ptr_t                tail_r;
  logic [COUNT_W-1:0]      count_r;

  rob_idx_t                        head_idx_s;
  rob_idx_t                        tail_idx_s;
  logic [COUNT_W-1:0]              free_s;
  logic [DCNT_W-1:0]               disp_cnt_s;
  logic [RCNT_W-1:0]               ret_cnt_s;
  rob_idx_t [RETIRE_WIDTH-1:0]     win_idx_s;
  logic [RETIRE_WIDTH-1:0]         win_valid_s;
  logic [RETIRE_WIDTH-1:0]         win_done_s;
  logic [RETIRE_WIDTH-1:0]         win_mispred_s;
  logic [NUM_ROB_ENTS-1:0]         cmp_hit_s;
  logic [NUM_ROB_ENTS-1:0]         cmp_mp_s;

  assign head_idx_s = head_r[ROB_IDX_W-1:0];
  assign tail_idx_s = tail_r[ROB_IDX_W-1:0];
  assign rob_count  = count_r;
  // Equal pointers including the wrap bit means nothing is in flight
  assign rob_empty  = (head_r == tail_r);

  // Dispatch acceptance and per-lane allocation indices
  always_comb begin
    free_s       = COUNT_W'(NUM_ROB_ENTS) - count_r;
    disp_ready   = (free_s >= COUNT_W'(DISP_WIDTH)) && !flush;
    disp_cnt_s   = disp_ready ? disp_popcount(disp_valid) : DCNT_W'(0);
    disp_rob_idx = '0;
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_rob_idx[i] = tail_idx_s + ROB_IDX_W'(i);
    end
  end

  // Head window gather for retire selection and retire payload
  always_comb begin
    win_idx_s     = '0;
    win_valid_s   = '0;
    win_done_s    = '0;
    win_mispred_s = '0;
    ret_areg      = '0;
    ret_preg      = '0;
    ret_old_preg  = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      win_idx_s[k]     = head_idx_s + ROB_IDX_W'(k);
      win_valid_s[k]   = valid_r[win_idx_s[k]];
      win_done_s[k]    = ents_r[win_idx_s[k]].done;
      win_mispred_s[k] = ents_r[win_idx_s[k]].mispred;
      ret_areg[k]      = ents_r[win_idx_s[k]].areg;
      ret_preg[k]      = ents_r[win_idx_s[k]].preg;
      ret_old_preg[k]  = ents_r[win_idx_s[k]].old_preg;
    end
  end

  // Completion ports decoded per entry so same-index hits OR together
  always_comb begin
    cmp_hit_s = '0;
    cmp_mp_s  = '0;
    for (int f = 0; f < NUM_FUS; f++) begin
      cmp_hit_s[cmp_rob_idx[f]] = cmp_hit_s[cmp_rob_idx[f]] | cmp_valid[f];
      cmp_mp_s[cmp_rob_idx[f]]  = cmp_mp_s[cmp_rob_idx[f]] | (cmp_valid[f] & cmp_mispred[f]);
    end
  end

  rob_retire_sel u_retire_sel (
    .win_valid   (win_valid_s),
    .win_done    (win_done_s),
    .win_mispred (win_mispred_s),
    .ret_valid   (ret_valid),
    .ret_cnt     (ret_cnt_s),
    .flush       (flush)
  );

  // Entry, pointer and occupancy state update
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        ents_r[e] <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= COUNT_W'(0);
    end else if (flush) begin
      // The mispredicted branch retires; everything younger is discarded
      valid_r <= '0;
      head_r  <= head_r + PTR_W'(ret_cnt_s);
      tail_r  <= head_r + PTR_W'(ret_cnt_s);
      count_r <= COUNT_W'(0);
    end else begin
      for (int e = 0; e < NUM_ROB_ENTS; e++) begin
        if (valid_r[e] && cmp_hit_s[e]) begin
          ents_r[e].done    <= 1'b1;
          ents_r[e].mispred <= ents_r[e].mispred | cmp_mp_s[e];
        end
      end
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (ret_valid[k]) begin
          valid_r[win_idx_s[k]] <= 1'b0;
        end
      end
      for (int i = 0; i < DISP_WIDTH; i++) begin
        if (disp_ready && disp_valid[i]) begin
          valid_r[disp_rob_idx[i]] <= 1'b1;
          ents_r[disp_rob_idx[i]]  <= '{areg:      disp_areg[i],
                                        preg:      disp_preg[i],
                                        old_preg:  disp_old_preg[i],
                                        is_branch: disp_is_branch[i],
                                        done:      1'b0,
                                        mispred:   1'b0};
        end
      end
      head_r  <= head_r + PTR_W'(ret_cnt_s);
      tail_r  <= tail_r + PTR_W'(disp_cnt_s);
      count_r <= count_r + COUNT_W'(disp_cnt_s) - COUNT_W'(ret_cnt_s);
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed bench for rob_multiport with a program-order queue model checked every cycle.
module tb_rob_multiport;
  import rob_multiport_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                 rst;
  logic [DISP_WIDTH-1:0]                disp_valid;
  logic [DISP_WIDTH-1:0][AREG_W-1:0]    disp_areg;
  logic [DISP_WIDTH-1:0][PREG_W-1:0]    disp_preg;
  logic [DISP_WIDTH-1:0][PREG_W-1:0]    disp_old_preg;
  logic [DISP_WIDTH-1:0]                disp_is_branch;
  logic                                 disp_ready;
  logic [DISP_WIDTH-1:0][ROB_IDX_W-1:0] disp_rob_idx;
  logic [NUM_FUS-1:0]                   cmp_valid;
  logic [NUM_FUS-1:0][ROB_IDX_W-1:0]    cmp_rob_idx;
  logic [NUM_FUS-1:0]                   cmp_mispred;
  logic [RETIRE_WIDTH-1:0]              ret_valid;
  logic [RETIRE_WIDTH-1:0][AREG_W-1:0]  ret_areg;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]  ret_preg;
  logic [RETIRE_WIDTH-1:0][PREG_W-1:0]  ret_old_preg;
  logic                                 flush;
  logic [COUNT_W-1:0]                   rob_count;
  logic                                 rob_empty;

  rob_multiport dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_areg(disp_areg), .disp_preg(disp_preg),
    .disp_old_preg(disp_old_preg), .disp_is_branch(disp_is_branch),
    .disp_ready(disp_ready), .disp_rob_idx(disp_rob_idx),
    .cmp_valid(cmp_valid), .cmp_rob_idx(cmp_rob_idx), .cmp_mispred(cmp_mispred),
    .ret_valid(ret_valid), .ret_areg(ret_areg), .ret_preg(ret_preg),
    .ret_old_preg(ret_old_preg), .flush(flush),
    .rob_count(rob_count), .rob_empty(rob_empty)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model: oldest entry at mq[0] ----------------
  typedef struct {
    int areg;
    int preg;
    int old;
    bit done;
    bit mp;
  } m_ent_t;

  m_ent_t mq[$];
  int     mhead = 0;
  bit     live = 1'b0;

  always @(negedge clk) begin : model_cmp
    int     n;
    int     tl;
    int     pos;
    bit     ef;
    bit     er;
    m_ent_t e;
    n = 0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      if (n == k && k < mq.size() && mq[k].done && !(k > 0 && mq[k-1].mp)) n = k + 1;
    end
    ef = (n > 0) && mq[n-1].mp;
    er = ((NUM_ROB_ENTS - mq.size()) >= DISP_WIDTH) && !ef;
    tl = (mhead + mq.size()) % NUM_ROB_ENTS;
    if (live) begin
      chk("m_count", rob_count, mq.size());
      chk("m_empty", rob_empty, (mq.size() == 0) ? 1 : 0);
      chk("m_ready", disp_ready, er ? 1 : 0);
      for (int i = 0; i < DISP_WIDTH; i++) chk("m_disp_idx", disp_rob_idx[i], (tl + i) % NUM_ROB_ENTS);
      chk("m_ret_valid", ret_valid, (1 << n) - 1);
      chk("m_flush", flush, ef ? 1 : 0);
      for (int k = 0; k < n; k++) begin
        chk("m_ret_areg", ret_areg[k], mq[k].areg);
        chk("m_ret_preg", ret_preg[k], mq[k].preg);
        chk("m_ret_old", ret_old_preg[k], mq[k].old);
      end
    end
    if (rst) begin
      mq.delete();
      mhead = 0;
      live  = 1'b1;
    end else begin
      for (int f = 0; f < NUM_FUS; f++) begin
        if (cmp_valid[f]) begin
          pos = ((int'(cmp_rob_idx[f]) - mhead) % NUM_ROB_ENTS + NUM_ROB_ENTS) % NUM_ROB_ENTS;
          if (pos < mq.size()) begin
            e = mq[pos];
            e.done = 1'b1;
            e.mp = e.mp | cmp_mispred[f];
            mq[pos] = e;
          end
        end
      end
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      mhead = (mhead + n) % NUM_ROB_ENTS;
      if (ef) begin
        mq.delete();
      end else if (er) begin
        for (int i = 0; i < DISP_WIDTH; i++) begin
          if (disp_valid[i]) begin
            e.areg = int'(disp_areg[i]);
            e.preg = int'(disp_preg[i]);
            e.old  = int'(disp_old_preg[i]);
            e.done = 1'b0;
            e.mp   = 1'b0;
            mq.push_back(e);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int seq = 0;

  task automatic idle();
    disp_valid = '0; disp_areg = '0; disp_preg = '0; disp_old_preg = '0; disp_is_branch = '0;
    cmp_valid = '0; cmp_rob_idx = '0; cmp_mispred = '0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Lane fields follow seq: areg = seq, preg = seq+35, old_preg = seq+70
  task automatic disp(input int nv, input logic [1:0] br);
    for (int i = 0; i < DISP_WIDTH; i++) begin
      disp_valid[i]     = (i < nv) ? 1'b1 : 1'b0;
      disp_areg[i]      = AREG_W'(seq + i);
      disp_preg[i]      = PREG_W'(seq + i + 35);
      disp_old_preg[i]  = PREG_W'(seq + i + 70);
      disp_is_branch[i] = br[i];
    end
    seq += nv;
  endtask

  task automatic cmp(input int port, input int idx, input bit mp);
    cmp_valid[port]   = 1'b1;
    cmp_rob_idx[port] = ROB_IDX_W'(idx);
    cmp_mispred[port] = mp;
  endtask

  task automatic do_reset();
    next(); rst = 1'b1;
    next(); rst = 1'b0;
    seq = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    sample();
    chk("rst_empty", rob_empty, 1);
    chk("rst_count", rob_count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_ret_valid", ret_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_idx0", disp_rob_idx[0], 0);
    chk("rst_idx1", disp_rob_idx[1], 1);

    // Two-lane dispatch, out-of-order completion, paired retire
    next(); seq = 5; disp(2, 2'b00); sample();
    chk("d2_idx0", disp_rob_idx[0], 0);
    chk("d2_idx1", disp_rob_idx[1], 1);
    next(); cmp(0, 1, 1'b0); sample();
    chk("d2_count", rob_count, 2);
    next(); cmp(0, 0, 1'b0); sample();
    chk("d2_no_ret", ret_valid, 0);
    next(); sample();
    chk("d2_ret_valid", ret_valid, 2'b11);
    chk("d2_ret_areg0", ret_areg[0], 5);
    chk("d2_ret_areg1", ret_areg[1], 6);
    chk("d2_ret_preg1", ret_preg[1], 41);
    next(); sample();
    chk("d2_empty", rob_empty, 1);

    // Fill to full, retire two, wrap allocation
    do_reset();
    for (int c = 0; c < NUM_ROB_ENTS / DISP_WIDTH; c++) begin
      disp(2, 2'b00);
      next();
    end
    disp(2, 2'b00); cmp(0, 0, 1'b0); cmp(1, 1, 1'b0); sample();
    chk("full_ready", disp_ready, 0);
    chk("full_count", rob_count, 64);
    next(); disp(2, 2'b00); sample();
    chk("full_ret", ret_valid, 2'b11);
    chk("full_ready_ret", disp_ready, 0);
    next(); disp(2, 2'b00); sample();
    chk("wrap_count", rob_count, 62);
    chk("wrap_ready", disp_ready, 1);
    chk("wrap_idx0", disp_rob_idx[0], 0);
    chk("wrap_idx1", disp_rob_idx[1], 1);
    next(); sample();
    chk("wrap_refull", rob_count, 64);

    // Mispredicted branch at idx 4 retires with flush; head at 3
    do_reset();
    disp(2, 2'b00);
    next(); disp(2, 2'b00);
    next(); disp(2, 2'b01);
    next(); disp(2, 2'b00); cmp(0, 0, 1'b0); cmp(1, 1, 1'b0); cmp(2, 2, 1'b0);
    next(); sample();
    chk("fl_ret01", ret_valid, 2'b11);
    next(); cmp(0, 3, 1'b0); cmp(1, 4, 1'b1); cmp(2, 5, 1'b0); cmp(3, 6, 1'b0); sample();
    chk("fl_ret2", ret_valid, 2'b01);
    next(); disp(2, 2'b00); cmp(0, 7, 1'b0); sample();
    chk("fl_ret_valid", ret_valid, 2'b11);
    chk("fl_flush", flush, 1);
    chk("fl_ret_areg1", ret_areg[1], 4);
    chk("fl_count_pre", rob_count, 5);
    chk("fl_ready", disp_ready, 0);
    next(); sample();
    chk("fl_count", rob_count, 0);
    chk("fl_empty", rob_empty, 1);
    chk("fl_no_ret", ret_valid, 0);
    chk("fl_idx0", disp_rob_idx[0], 5);

    // Dispatch + retire + completion in one cycle at count 10
    do_reset();
    for (int c = 0; c < 5; c++) begin
      disp(2, 2'b00);
      if (c == 4) begin
        cmp(0, 0, 1'b0); cmp(1, 1, 1'b0);
      end
      next();
    end
    disp(2, 2'b00); cmp(0, 7, 1'b0); sample();
    chk("mix_count_pre", rob_count, 10);
    chk("mix_ret", ret_valid, 2'b11);
    next(); cmp(0, 2, 1'b0); cmp(1, 3, 1'b0); cmp(2, 4, 1'b0); cmp(3, 5, 1'b0); sample();
    chk("mix_count", rob_count, 10);
    next(); cmp(0, 6, 1'b0);
    next();
    next(); sample();
    chk("mix_ret67", ret_valid, 2'b11);
    chk("mix_areg7", ret_areg[1], 7);
    next(); sample();
    chk("mix_count_end", rob_count, 4);

    // Reset mid-operation with 20 valid entries and an active dispatch
    for (int c = 0; c < 8; c++) begin
      disp(2, 2'b00);
      next();
    end
    disp(2, 2'b00); rst = 1'b1; sample();
    chk("mr_count_pre", rob_count, 20);
    next(); rst = 1'b0; disp(2, 2'b00); sample();
    chk("mr_count", rob_count, 0);
    chk("mr_idx0", disp_rob_idx[0], 0);
    chk("mr_idx1", disp_rob_idx[1], 1);
    next(); sample();
    chk("mr_count_after", rob_count, 2);

    next(); next();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
